dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder on the far end of the processor's dmem port: it accepts `address_dmem`, `data` and `wren` from the pipeline and returns `q_dmem`. It is a word-addressed synchronous RAM with one-cycle read latency and write-first read-during-write behaviour. A post-reset init sequencer zeroes every word, and a sticky flag records out-of-range accesses. It sits in the wrapper beside the regfile and imem, in place of a bare RAM.

## Interface
- `ADDR_WIDTH`, 12, number of word-address bits decoded into the RAM.
- `DEPTH`, 4096, number of 32-bit words; must equal 2^ADDR_WIDTH.
- `clock`  in  1  master clock; all state updates on the rising edge.
- `reset`  in  1  one clock; reset is asynchronous and active-low.
- `address_dmem`  in  32  word address from the processor's M stage.
- `data`  in  32  store data.
- `wren`  in  1  store enable.
- `q_dmem`  out  32  registered load data.
- `busy`  out  1  high while the init sequencer runs.
- `addr_err`  out  1  sticky out-of-range access flag.

## Operation
- FSM states are INIT and READY.
  - Reset asserted: state=INIT, init index=0, `q_dmem`=0, `busy`=1, `addr_err`=0, counters=0.
  - INIT: each cycle writes 0 to RAM[index] and increments index. After index DEPTH-1 is written, the next state is READY.
  - INIT: processor writes are dropped, reads return 0, and `addr_err` does not update.
  - READY: normal service. The FSM never leaves READY except via reset.
- Address decode:
  - In range: `address_dmem[31:ADDR_WIDTH]`==0. Index is `address_dmem[ADDR_WIDTH-1:0]`.
  - Out of range, non-MMIO: writes are dropped, the read returns 0, and `addr_err` is set. It stays set until reset.
- Write: with `wren`=1 and an in-range address, RAM[index] takes `data` at the edge.
- Read: every cycle `q_dmem` registers RAM[index] for the address presented at that edge. Loads need no separate enable.
- Read-during-write, same address, same edge: `q_dmem` returns the new `data` (write-first).
- No byte enables; all accesses are full 32-bit words.

## Timing
- Read latency is exactly 1 cycle: the address at edge n gives `q_dmem` valid after edge n, for use in the W stage.
- Write takes effect at the edge. A read of the same address at edge n+1 sees the new value.
- `busy` goes 1 asynchronously on reset and stays 1 for exactly DEPTH rising edges after reset is released. It is 0 from the edge that completes index DEPTH-1.
- Reset asserted mid-INIT restarts the sweep at index 0.
- Reset asserted mid-READY returns the block to INIT. RAM is re-zeroed; its prior contents are lost.
- `addr_err` sets at the edge where the offending access is sampled. Simultaneous error and reset: reset wins.

## Configuration
- `DMEM_MMIO_EN` defined: two read-only registers are mapped.
  - 0xFFFF_FFFE is a free-running cycle counter. It counts every READY cycle and wraps at 2^32.
  - 0xFFFF_FFFF is a store counter. It counts accepted in-range writes in READY and wraps at 2^32.
  - Reads of these addresses return the counter value before the current edge's increment, with the same 1-cycle latency.
  - Writes to these addresses are ignored and do not set `addr_err`.
- `DMEM_MMIO_EN` undefined: both addresses are ordinary out-of-range accesses. They return 0, set `addr_err`, and no counter logic is built.

## Test plan
- Init: hold `reset`=0 for 3 cycles, then release. Required: `busy`=1 for DEPTH edges then 0; reads of addresses 0, 1 and 4095 then return 0.
- Write/read: write 0xDEADBEEF to address 5, then read address 5 on the next edge. Required: `q_dmem`=0xDEADBEEF one cycle after the read address.
- Write-first: in the same cycle, `wren`=1, address 7, `data`=0x12345678. Required: `q_dmem`=0x12345678 after that edge.
- Out of range: write to 0x0000_1000. Required: `addr_err`=1; a read of 0x0000_1000 returns 0; RAM[0] is unchanged.
- Reset mid-INIT: assert `reset` at sweep index 100, release 2 cycles later. Required: `busy` stays 1 for a further DEPTH edges.
- MMIO (`DMEM_MMIO_EN`): do 3 in-range stores, then read 0xFFFF_FFFF. Required: `q_dmem`=3 and `addr_err`=0. Two consecutive reads of 0xFFFF_FFFE must differ by 1.

Source files
------------

// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder: 1-cycle write-first RAM, post-reset zeroing sweep,
// sticky out-of-range flag. Define DMEM_MMIO_EN to map the cycle/store counters at the top.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DEPTH      = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic        busy,
  output logic        addr_err
);

  typedef enum logic {StInit, StReady} state_e;

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(DEPTH - 1);

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_init_idx;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_in_range;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_bad;
  logic [31:0]           w_rdata;
  logic                  w_ram_we;
  logic [ADDR_WIDTH-1:0] w_ram_idx;
  logic [31:0]           w_ram_wdata;

  assign w_in_range = (address_dmem[31:ADDR_WIDTH] == '0);
  assign w_idx      = address_dmem[ADDR_WIDTH-1:0];

`ifdef DMEM_MMIO_EN
  logic        w_is_cyc;
  logic        w_is_st;
  logic [31:0] r_cyc_cnt;
  logic [31:0] r_st_cnt;

  assign w_is_cyc = (address_dmem == 32'hFFFF_FFFE);
  assign w_is_st  = (address_dmem == 32'hFFFF_FFFF);
  assign w_bad    = !w_in_range && !w_is_cyc && !w_is_st;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cyc_cnt <= '0;
      r_st_cnt  <= '0;
    end else if (r_state == StReady) begin
      r_cyc_cnt <= r_cyc_cnt + 32'd1;
      if (wren && w_in_range) r_st_cnt <= r_st_cnt + 32'd1;
    end
  end
`else
  assign w_bad = !w_in_range;
`endif

  // Write-first: a same-edge store forwards its data to the load.
  always_comb begin
    w_rdata = '0;
    if (w_in_range) begin
      w_rdata = wren ? data : r_mem[w_idx];
    end
`ifdef DMEM_MMIO_EN
    else if (w_is_cyc) begin
      w_rdata = r_cyc_cnt;
    end else if (w_is_st) begin
      w_rdata = r_st_cnt;
    end
`endif
  end

  // The sweep owns the RAM port during INIT; processor stores are dropped.
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_idx   = w_idx;
    w_ram_wdata = data;
    if (r_state == StInit) begin
      w_ram_we    = 1'b1;
      w_ram_idx   = r_init_idx;
      w_ram_wdata = '0;
    end else if (wren && w_in_range) begin
      w_ram_we = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_ram_we) r_mem[w_ram_idx] <= w_ram_wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= StInit;
      r_init_idx <= '0;
      q_dmem     <= '0;
      busy       <= 1'b1;
      addr_err   <= 1'b0;
    end else begin
      unique case (r_state)
        StInit: begin
          q_dmem     <= '0;
          r_init_idx <= r_init_idx + ADDR_WIDTH'(1);
          if (r_init_idx == LastIdx) begin
            r_state <= StReady;
            busy    <= 1'b0;
          end
        end
        StReady: begin
          q_dmem <= w_rdata;
          if (w_bad) addr_err <= 1'b1;
        end
        default: r_state <= StInit;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed steps plus randomized traffic scored
// against an array-based memory model. Exercises the MMIO map when DMEM_MMIO_EN is defined.
module tb_dmem_responder;

  localparam int unsigned AW = 12;
  localparam int unsigned D  = 4096;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address_dmem = '0;
  logic [31:0] data = '0;
  logic        wren = 1'b0;
  logic [31:0] q_dmem;
  logic        busy;
  logic        addr_err;

  dmem_responder #(
    .ADDR_WIDTH(AW),
    .DEPTH     (D)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .address_dmem(address_dmem),
    .data        (data),
    .wren        (wren),
    .q_dmem      (q_dmem),
    .busy        (busy),
    .addr_err    (addr_err)
  );

  always #5 clock = ~clock;

  logic [31:0] m_mem [D];
  bit          m_err;
  logic [31:0] m_cyc;
  logic [31:0] m_st;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    m_err = 1'b0;
    m_cyc = '0;
    m_st  = '0;
  endtask

  // One READY-state access: drive, clock, then score against the model.
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w,
                      input string tag);
    logic [31:0] e;
    address_dmem = a;
    data         = d;
    wren         = w;
    @(posedge clock);
    #1;
    if (a < D) begin
      e = w ? d : m_mem[a];
      if (w) begin
        m_mem[a] = d;
        m_st     = m_st + 1;
      end
    end
`ifdef DMEM_MMIO_EN
    else if (a == 32'hFFFF_FFFE) e = m_cyc;
    else if (a == 32'hFFFF_FFFF) e = m_st;
`endif
    else begin
      e     = '0;
      m_err = 1'b1;
    end
    m_cyc = m_cyc + 1;
    chk({tag, " q"}, q_dmem, e);
    chk({tag, " err"}, {31'b0, addr_err}, {31'b0, m_err});
    wren = 1'b0;
  endtask

  // Runs until busy drops (bounded), throwing junk accesses that must all be ignored.
  task automatic sweep(input int max_edges, output int edges, output int bad_q);
    edges = 0;
    bad_q = 0;
    while (busy && edges < max_edges) begin
      address_dmem = $urandom;
      if ($urandom_range(1) == 1) address_dmem[31:AW] = '0;
      data = $urandom;
      wren = 1'b1;
      @(posedge clock);
      #1;
      edges++;
      if (q_dmem !== 32'd0) bad_q++;
    end
    wren         = 1'b0;
    address_dmem = '0;
  endtask

  logic [31:0] a;
  logic [31:0] v1;
  int          edges;
  int          bad_q;

  initial begin
    model_reset();
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst busy", {31'b0, busy}, 32'd1);
    chk("rst q", q_dmem, 32'd0);
    chk("rst err", {31'b0, addr_err}, 32'd0);
    reset = 1'b1;
    #1;
    chk("rel busy", {31'b0, busy}, 32'd1);

    sweep(D + 50, edges, bad_q);
    chk("init edges", edges, D);
    chk("init q zero", bad_q, 32'd0);
    chk("init err", {31'b0, addr_err}, 32'd0);

    step(32'd0, 32'd0, 1'b0, "rd 0");
    step(32'd1, 32'd0, 1'b0, "rd 1");
    step(32'd4095, 32'd0, 1'b0, "rd 4095");

`ifdef DMEM_MMIO_EN
    step(32'd10, 32'h1111_0001, 1'b1, "st a");
    step(32'd11, 32'h1111_0002, 1'b1, "st b");
    step(32'd12, 32'h1111_0003, 1'b1, "st c");
    step(32'hFFFF_FFFF, 32'd0, 1'b0, "rd stcnt");
    chk("stcnt 3", q_dmem, 32'd3);
    chk("stcnt err", {31'b0, addr_err}, 32'd0);
    step(32'hFFFF_FFFE, 32'd0, 1'b0, "rd cyc1");
    v1 = q_dmem;
    step(32'hFFFF_FFFE, 32'd0, 1'b0, "rd cyc2");
    chk("cyc diff", q_dmem - v1, 32'd1);
`endif

    step(32'd5, 32'hDEAD_BEEF, 1'b1, "wr 5");
    step(32'd5, 32'd0, 1'b0, "rd 5");
    chk("rd 5 val", q_dmem, 32'hDEAD_BEEF);
    step(32'd7, 32'h1234_5678, 1'b1, "wf 7");
    chk("wf 7 val", q_dmem, 32'h1234_5678);

    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(3) == 0) ? 32'($urandom_range(D - 1)) : 32'($urandom_range(15));
      step(a, $urandom, 1'($urandom_range(1)), "rnd");
    end

    step(32'd0, 32'hA5A5_0000, 1'b1, "wr 0");
    step(32'h0000_1000, 32'hBAD0_BAD0, 1'b1, "oor wr");
    chk("oor err set", {31'b0, addr_err}, 32'd1);
    step(32'h0000_1000, 32'd0, 1'b0, "oor rd");
    chk("oor rd zero", q_dmem, 32'd0);
    step(32'd0, 32'd0, 1'b0, "rd 0 kept");
    chk("ram0 kept", q_dmem, 32'hA5A5_0000);

    for (int i = 0; i < 100; i++) begin
      a = ($urandom_range(9) == 0) ? 32'h0000_1000 + 32'($urandom_range(100))
                                   : 32'($urandom_range(31));
      step(a, $urandom, 1'($urandom_range(1)), "rnd2");
    end

    // Reset mid-READY, then again mid-INIT at sweep index 100.
    #1 reset = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (100) @(posedge clock);
    #1;
    chk("mid busy", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("mid rst err", {31'b0, addr_err}, 32'd0);
    reset = 1'b1;
    model_reset();
    sweep(D + 50, edges, bad_q);
    chk("reinit edges", edges, D);
    chk("reinit q zero", bad_q, 32'd0);

    step(32'd5, 32'd0, 1'b0, "rezero 5");
    chk("rezero 5 val", q_dmem, 32'd0);

`ifdef DMEM_MMIO_EN
    step(32'hFFFF_FFFF, 32'h0000_0099, 1'b1, "mmio wr");
    chk("mmio wr err", {31'b0, addr_err}, 32'd0);
    step(32'hFFFF_FFFE, 32'd0, 1'b0, "mmio cyc");
`else
    step(32'hFFFF_FFFF, 32'd0, 1'b0, "nommio rd");
    chk("nommio err", {31'b0, addr_err}, 32'd1);
    step(32'hFFFF_FFFE, 32'd0, 1'b0, "nommio rd2");
    chk("nommio q", q_dmem, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
